// File: rtl/instr_feeder_pkg.sv
// Shared constants, types and helpers for the instruction feeder.
package instr_feeder_pkg;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   localparam logic [DW-1:0] NOP_WORD = 8'h00;  // mv r0,r0

   // Processor opcode field op[7:6]; the feeder never decodes these.
   localparam logic [1:0] OP_MV  = 2'b00;
   localparam logic [1:0] OP_MVI = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_req_t;

   localparam int            DEPTH_I   = DEPTH;
   localparam logic [AW:0]   DEPTH_LEN = DEPTH_I[AW:0];

   // Requested length saturated to the memory depth (no wrap).
   function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
      return (len > DEPTH_LEN) ? DEPTH_LEN : len;
   endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Host-side bus of the instruction feeder: program write port, run control and outputs.
interface instr_feeder_if;
   import instr_feeder_pkg::*;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic          hold;
   logic          abort;
   logic [DW-1:0] dout;
   logic          busy;
   logic          done;
   logic [AW:0]   pc;

   modport master (
      output wr_en, wr_addr, wr_data, prog_len, start, hold, abort,
      input  dout, busy, done, pc
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, prog_len, start, hold, abort,
      output dout, busy, done, pc
   );

endinterface

// File: rtl/instr_feeder_prog_ram.sv
// Program store: synchronous write, combinational read, cleared by reset.
module instr_feeder_prog_ram
   import instr_feeder_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  wr_req_t       wr,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DEPTH-1:0][DW-1:0] mem;

   // Word write; reset wipes the whole program
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem <= '0;
      else if (wr.en)
         mem[wr.addr] <= wr.data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_feeder.sv
// Replays a loaded program onto the processor din bus, one word per clock,
// with hold pacing, abort, and a one-cycle done pulse at the end.
module instr_feeder
   import instr_feeder_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   instr_feeder_if.slave  bus
);

   state_t        state;
   logic [DW-1:0] dout_r;
   logic [AW:0]   pc_r;
   logic [AW:0]   len_r;
   logic          busy_r;
   logic          done_r;

   logic [AW:0]   start_len;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] first_word;
   wr_req_t       wr;

   // Program is frozen while it is being issued
   assign wr.en   = bus.wr_en && (state != ST_RUN);
   assign wr.addr = bus.wr_addr;
   assign wr.data = bus.wr_data;

   instr_feeder_prog_ram u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Outside RUN the read port looks at word 0 so a start can issue it directly.
   // pc == DEPTH aliases to 0 here, but that read is never used.
   assign rd_addr    = (state == ST_RUN) ? pc_r[AW-1:0] : '0;
   assign start_len  = clamp_len(bus.prog_len);
   // A same-cycle write to word 0 wins over the stored value
   assign first_word = (bus.wr_en && (bus.wr_addr == '0)) ? bus.wr_data : rd_data;

   // Control FSM with registered dout/pc/busy/done; abort overrides start and hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         dout_r <= NOP_WORD;
         pc_r   <= '0;
         len_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (bus.abort) begin
         state  <= ST_IDLE;
         dout_r <= NOP_WORD;
         pc_r   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (!bus.hold) begin
                  if (pc_r < len_r) begin
                     dout_r <= rd_data;
                     pc_r   <= pc_r + 1'b1;
                  end else begin
                     dout_r <= NOP_WORD;
                     state  <= ST_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end
               end
            end
            default: begin  // IDLE and DONE behave alike; DONE never lingers
               state  <= ST_IDLE;
               dout_r <= NOP_WORD;
               done_r <= 1'b0;
               if (bus.start) begin
                  len_r <= start_len;
                  if (start_len != '0) begin
                     dout_r <= first_word;
                     pc_r   <= {{AW{1'b0}}, 1'b1};
                     state  <= ST_RUN;
                     busy_r <= 1'b1;
                  end else begin
                     state  <= ST_DONE;
                     done_r <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.dout = dout_r;
   assign bus.pc   = pc_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
